cond_flag_unit: RTL and testbench

//   Producer side of the NZCV condition interface for the multicycle ARM core.

---
 rtl/cond_flag_unit_if.sv | 29 ++
 rtl/cond_flag_unit.sv | 94 +++++++++
 tb/tb_cond_flag_unit.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/cond_flag_unit_if.sv
// NZCV condition interface between the controller/ALU side (master) and the
// condition/flag unit (slave).
interface cond_flag_unit_if;
  logic [3:0] Cond;
  logic       cond_valid;
  logic [3:0] ALUFlags;
  logic       alu_valid;
  logic [1:0] FlagW;
  logic       PCS;
  logic       RegW;
  logic       MemW;
  logic       NextPC;
  logic       PCWrite;
  logic       RegWrite;
  logic       MemWrite;
  logic [3:0] Flags;
  logic       CondEx;
  logic       busy;

  modport master (
    output Cond, cond_valid, ALUFlags, alu_valid, FlagW, PCS, RegW, MemW, NextPC,
    input  PCWrite, RegWrite, MemWrite, Flags, CondEx, busy
  );

  modport slave (
    input  Cond, cond_valid, ALUFlags, alu_valid, FlagW, PCS, RegW, MemW, NextPC,
    output PCWrite, RegWrite, MemWrite, Flags, CondEx, busy
  );
endinterface

// File: rtl/cond_flag_unit.sv
// Owns the NZCV flag register, evaluates the condition of the in-flight
// instruction and gates the PC / register-file / memory write enables.
module cond_flag_unit #(
  parameter logic [3:0] RESET_FLAGS = 4'b0000,
  parameter bit         FLAG_BYPASS = 1'b1
) (
  input logic            clk,
  input logic            reset,
  cond_flag_unit_if.slave bus
);

  typedef enum logic {IDLE, HELD} state_t;

  state_t     state_q, state_d;
  logic       condex_q, condex_d;
  logic [3:0] flags_q, flags_d;
  logic [3:0] eval_flags;
  logic       held;
  logic       commit;
  logic       gate;

  function automatic logic eval_cond(input logic [3:0] cond, input logic [3:0] f);
    logic n, z, c, v, ge, res;
    {n, z, c, v} = f;
    ge = (n == v);
    case (cond)
      4'b0000: res = z;
      4'b0001: res = ~z;
      4'b0010: res = c;
      4'b0011: res = ~c;
      4'b0100: res = n;
      4'b0101: res = ~n;
      4'b0110: res = v;
      4'b0111: res = ~v;
      4'b1000: res = c & ~z;
      4'b1001: res = ~(c & ~z);
      4'b1010: res = ge;
      4'b1011: res = ~ge;
      4'b1100: res = ~z & ge;
      4'b1101: res = ~(~z & ge);
      4'b1110: res = 1'b1;
      4'b1111: res = 1'b0;
    endcase
    return res;
  endfunction

  assign held = (state_q == HELD);

  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    commit   = held & bus.alu_valid & condex_q;
    flags_d  = flags_q;
    state_d  = state_q;
    condex_d = condex_q;

    if (commit) begin
      if (bus.FlagW[1]) flags_d[3:2] = bus.ALUFlags[3:2];
      if (bus.FlagW[0]) flags_d[1:0] = bus.ALUFlags[1:0];
    end

    // With bypass, an evaluation in a commit cycle sees the merged new flags.
    eval_flags = FLAG_BYPASS ? flags_d : flags_q;

    if (bus.cond_valid) begin
      state_d  = HELD;
      condex_d = eval_cond(bus.Cond, eval_flags);
    end else if (held && bus.alu_valid) begin
      state_d = IDLE;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only; reset is synchronous.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      condex_q <= 1'b0;
      flags_q  <= RESET_FLAGS;
    end else begin
      state_q  <= state_d;
      condex_q <= condex_d;
      flags_q  <= flags_d;
    end
  end

  // Reset suppresses every write enable, including a pending commit.
  assign gate         = ~reset & held & condex_q & bus.alu_valid;
  assign bus.PCWrite  = ~reset & (bus.NextPC | (gate & bus.PCS));
  assign bus.RegWrite = gate & bus.RegW;
  assign bus.MemWrite = gate & bus.MemW;
  assign bus.Flags    = flags_q;
  assign bus.CondEx   = held & condex_q;
  assign bus.busy     = held & ~reset;

endmodule

// File: tb/tb_cond_flag_unit.sv
// Self-checking bench: two instances (bypass on / off) share stimulus and are
// compared cycle by cycle against a behavioural model, plus directed vectors.
module tb_cond_flag_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic [3:0] cond, alu_flags;
  logic       cond_valid, alu_valid, pcs, regw, memw, next_pc;
  logic [1:0] flag_w;

  cond_flag_unit_if bus_n ();
  cond_flag_unit_if bus_b ();

  assign bus_n.Cond = cond;       assign bus_b.Cond = cond;
  assign bus_n.cond_valid = cond_valid; assign bus_b.cond_valid = cond_valid;
  assign bus_n.ALUFlags = alu_flags; assign bus_b.ALUFlags = alu_flags;
  assign bus_n.alu_valid = alu_valid; assign bus_b.alu_valid = alu_valid;
  assign bus_n.FlagW = flag_w;    assign bus_b.FlagW = flag_w;
  assign bus_n.PCS = pcs;         assign bus_b.PCS = pcs;
  assign bus_n.RegW = regw;       assign bus_b.RegW = regw;
  assign bus_n.MemW = memw;       assign bus_b.MemW = memw;
  assign bus_n.NextPC = next_pc;  assign bus_b.NextPC = next_pc;

  cond_flag_unit #(.RESET_FLAGS(4'b0000), .FLAG_BYPASS(1'b0)) dut_n (
    .clk(clk), .reset(reset), .bus(bus_n.slave));
  cond_flag_unit #(.RESET_FLAGS(4'b0000), .FLAG_BYPASS(1'b1)) dut_b (
    .clk(clk), .reset(reset), .bus(bus_b.slave));

  int n_checks = 0;
  int n_pass   = 0;

  // Model state, index 0 = no bypass, 1 = bypass.
  bit       m_held [2];
  bit       m_cex  [2];
  bit [3:0] m_flags[2];

  logic seen_pcw, seen_regw, seen_memw;

  typedef struct {
    logic [3:0] flags;
    logic [3:0] cond;
    logic       exp;
  } vec_t;
  vec_t vecs[21];

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %b expected %b (t=%0t)", name, act, exp, $time);
  endtask

  function automatic bit ref_eval(input bit [3:0] c, input bit [3:0] f);
    bit n, z, cy, v, base;
    n = f[3]; z = f[2]; cy = f[1]; v = f[0];
    if (c == 4'b1110) return 1'b1;
    if (c == 4'b1111) return 1'b0;
    case (c[3:1])
      3'd0: base = z;
      3'd1: base = cy;
      3'd2: base = n;
      3'd3: base = v;
      3'd4: base = cy && !z;
      3'd5: base = (n == v);
      default: base = !z && (n == v);
    endcase
    return base ^ c[0];
  endfunction

  task automatic clear_inputs();
    reset = 0; cond = 0; cond_valid = 0; alu_flags = 0; alu_valid = 0;
    flag_w = 0; pcs = 0; regw = 0; memw = 0; next_pc = 0;
  endtask

  task automatic cycle();
    logic [3:0] a_pcw, a_regw, a_memw, a_busy, a_cex, a_flags;
    @(negedge clk);
    for (int k = 0; k < 2; k++) begin
      bit g;
      g = !reset && m_held[k] && m_cex[k] && alu_valid;
      a_pcw  = (k == 1) ? bus_b.PCWrite  : bus_n.PCWrite;
      a_regw = (k == 1) ? bus_b.RegWrite : bus_n.RegWrite;
      a_memw = (k == 1) ? bus_b.MemWrite : bus_n.MemWrite;
      a_busy = (k == 1) ? bus_b.busy     : bus_n.busy;
      check($sformatf("pcwrite%0d", k), a_pcw, 4'(!reset && (next_pc || (g && pcs))));
      check($sformatf("regwrite%0d", k), a_regw, 4'(g && regw));
      check($sformatf("memwrite%0d", k), a_memw, 4'(g && memw));
      check($sformatf("busy_pre%0d", k), a_busy, 4'(!reset && m_held[k]));
    end
    seen_pcw = bus_b.PCWrite; seen_regw = bus_b.RegWrite; seen_memw = bus_b.MemWrite;
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        m_flags[k] = 4'b0000; m_cex[k] = 0; m_held[k] = 0;
      end else begin
        bit [3:0] nf;
        nf = m_flags[k];
        if (m_held[k] && alu_valid && m_cex[k]) begin
          if (flag_w[1]) nf[3:2] = alu_flags[3:2];
          if (flag_w[0]) nf[1:0] = alu_flags[1:0];
        end
        if (cond_valid) begin
          m_held[k] = 1;
          m_cex[k]  = ref_eval(cond, (k == 1) ? nf : m_flags[k]);
        end else if (m_held[k] && alu_valid) begin
          m_held[k] = 0;
        end
        m_flags[k] = nf;
      end
    end
    #1;
    for (int k = 0; k < 2; k++) begin
      a_cex   = (k == 1) ? bus_b.CondEx : bus_n.CondEx;
      a_flags = (k == 1) ? bus_b.Flags  : bus_n.Flags;
      a_busy  = (k == 1) ? bus_b.busy   : bus_n.busy;
      check($sformatf("condex%0d", k), a_cex, 4'(m_held[k] && m_cex[k]));
      check($sformatf("flags%0d", k), a_flags, m_flags[k]);
      check($sformatf("busy%0d", k), a_busy, 4'(!reset && m_held[k]));
    end
  endtask

  // Load the flags through an AL instruction with full FlagW.
  task automatic set_flags(input logic [3:0] f);
    clear_inputs(); cond = 4'b1110; cond_valid = 1; cycle();
    clear_inputs(); alu_valid = 1; flag_w = 2'b11; alu_flags = f; cycle();
    clear_inputs();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    vecs[0]  = '{4'b0100, 4'b0000, 1'b1};
    vecs[1]  = '{4'b0000, 4'b0000, 1'b0};
    vecs[2]  = '{4'b0000, 4'b0001, 1'b1};
    vecs[3]  = '{4'b0010, 4'b0010, 1'b1};
    vecs[4]  = '{4'b0010, 4'b0011, 1'b0};
    vecs[5]  = '{4'b1000, 4'b0100, 1'b1};
    vecs[6]  = '{4'b1000, 4'b0101, 1'b0};
    vecs[7]  = '{4'b0001, 4'b0110, 1'b1};
    vecs[8]  = '{4'b0001, 4'b0111, 1'b0};
    vecs[9]  = '{4'b0010, 4'b1000, 1'b1};
    vecs[10] = '{4'b0110, 4'b1000, 1'b0};
    vecs[11] = '{4'b0110, 4'b1001, 1'b1};
    vecs[12] = '{4'b1001, 4'b1010, 1'b1};
    vecs[13] = '{4'b1000, 4'b1010, 1'b0};
    vecs[14] = '{4'b1000, 4'b1011, 1'b1};
    vecs[15] = '{4'b0000, 4'b1100, 1'b1};
    vecs[16] = '{4'b0100, 4'b1100, 1'b0};
    vecs[17] = '{4'b0001, 4'b1101, 1'b1};
    vecs[18] = '{4'b0000, 4'b1110, 1'b1};
    vecs[19] = '{4'b1111, 4'b1111, 1'b0};
    vecs[20] = '{4'b0000, 4'b1111, 1'b0};

    for (int k = 0; k < 2; k++) begin
      m_held[k] = 0; m_cex[k] = 0; m_flags[k] = 4'b0000;
    end

    // T1: two reset cycles with NextPC requested.
    clear_inputs(); reset = 1; next_pc = 1; cycle(); cycle();
    check("t1_pcwrite", seen_pcw, 4'd0);
    check("t1_flags", bus_b.Flags, 4'b0000);
    check("t1_condex", bus_b.CondEx, 4'd0);
    check("t1_busy", bus_b.busy, 4'd0);
    clear_inputs();

    // Condition table.
    foreach (vecs[i]) begin
      set_flags(vecs[i].flags);
      cond = vecs[i].cond; cond_valid = 1; cycle();
      check($sformatf("vec%0d_b", i), bus_b.CondEx, 4'(vecs[i].exp));
      check($sformatf("vec%0d_n", i), bus_n.CondEx, 4'(vecs[i].exp));
      clear_inputs(); alu_valid = 1; cycle(); clear_inputs();
    end

    // T2: EQ passes, register write granted.
    set_flags(4'b0100);
    cond = 4'b0000; cond_valid = 1; cycle();
    check("t2_condex", bus_b.CondEx, 4'd1);
    clear_inputs(); alu_valid = 1; regw = 1; cycle();
    check("t2_regwrite", seen_regw, 4'd1);
    check("t2_busy", bus_b.busy, 4'd0);

    // T3: failed condition writes nothing.
    set_flags(4'b0000);
    cond = 4'b0000; cond_valid = 1; cycle();
    clear_inputs(); alu_valid = 1; flag_w = 2'b11; alu_flags = 4'b1111; regw = 1; cycle();
    check("t3_regwrite", seen_regw, 4'd0);
    check("t3_flags", bus_b.Flags, 4'b0000);

    // T4: split FlagW groups.
    set_flags(4'b0011);
    cond = 4'b1110; cond_valid = 1; cycle();
    clear_inputs(); alu_valid = 1; flag_w = 2'b10; alu_flags = 4'b1100; cycle();
    check("t4_flags_a", bus_b.Flags, 4'b1111);
    clear_inputs(); cond = 4'b1110; cond_valid = 1; cycle();
    clear_inputs(); alu_valid = 1; flag_w = 2'b01; alu_flags = 4'b0000; cycle();
    check("t4_flags_b", bus_n.Flags, 4'b1100);

    // T5: evaluation in the commit cycle, with and without bypass.
    set_flags(4'b0000);
    cond = 4'b1110; cond_valid = 1; cycle();
    clear_inputs(); alu_valid = 1; flag_w = 2'b10; alu_flags = 4'b0100;
    cond = 4'b0000; cond_valid = 1; cycle();
    check("t5_condex_bypass", bus_b.CondEx, 4'd1);
    check("t5_condex_nobypass", bus_n.CondEx, 4'd0);
    check("t5_busy", bus_n.busy, 4'd1);
    clear_inputs(); alu_valid = 1; cycle(); clear_inputs();

    // T6: NV condition, alu_valid in IDLE, reset during a pending commit.
    set_flags(4'b1111);
    cond = 4'b1111; cond_valid = 1; cycle();
    check("t6_nv", bus_b.CondEx, 4'd0);
    clear_inputs(); alu_valid = 1; cycle();
    clear_inputs(); alu_valid = 1; flag_w = 2'b11; alu_flags = 4'b1010; cycle();
    check("t6_idle_alu", bus_b.Flags, 4'b1111);
    clear_inputs(); cond = 4'b1110; cond_valid = 1; cycle();
    clear_inputs(); reset = 1; alu_valid = 1; flag_w = 2'b11; alu_flags = 4'b0101;
    regw = 1; memw = 1; pcs = 1; next_pc = 1; cycle();
    check("t6_rst_pcwrite", seen_pcw, 4'd0);
    check("t6_rst_regwrite", seen_regw, 4'd0);
    check("t6_rst_memwrite", seen_memw, 4'd0);
    check("t6_rst_flags", bus_b.Flags, 4'b0000);
    check("t6_rst_busy", bus_b.busy, 4'd0);
    clear_inputs();

    // Randomized traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      reset      = ($urandom_range(0, 49) == 0);
      cond       = 4'($urandom);
      cond_valid = ($urandom_range(0, 2) == 0);
      alu_valid  = 1'($urandom);
      alu_flags  = 4'($urandom);
      flag_w     = 2'($urandom);
      pcs        = 1'($urandom);
      regw       = 1'($urandom);
      memw       = 1'($urandom);
      next_pc    = ($urandom_range(0, 3) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
